// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: sizes, requester
// indices, the writeback request record and a round-robin pointer helper.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int NUM_REQ    = 3;

    // Fixed requester slots on the shared write port
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Next round-robin start position after index idx has been served
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter. Grant is combinational from the request
// vector; the priority pointer moves just past the winner when the caller
// signals that the grant was consumed (i_advance).
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_k;
    logic             w_found;

    // Scan r_ptr, r_ptr+1, ... (mod N) and grant the first active request
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = '0;
        w_k         = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(N)) begin
                w_pos = w_pos - (IDX_W+1)'(N);
            end
            w_k = w_pos[IDX_W-1:0];
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_grant_idx  = w_k;
            end
        end
    end

    // Priority pointer: moves one past the consumed winner, otherwise holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= IDX_W'(rr_next(int'(o_grant_idx), N));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. Shares the
// port round-robin among ALU, load and mul/div, registers the winning write
// (one cycle latency) and tracks pending destinations for the issue stage.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] i_req_address,
    input  logic [NUM_REQ*XLEN-1:0]       i_req_data,
    input  logic                          i_reserve_valid,
    input  logic [REG_ADDR_W-1:0]         i_reserve_address,
    input  logic                          i_flush,
    output logic                          o_write_enable,
    output logic [REG_ADDR_W-1:0]         o_write_address,
    output logic [XLEN-1:0]               o_write_data,
    output logic [2**REG_ADDR_W-1:0]      o_busy_mask,
    output logic                          o_reserve_conflict
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREGS = 2**REG_ADDR_W;

    logic [NUM_REQ-1:0]    w_req_eff;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_accept;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_sel_nonzero;
    logic                  w_rsv_nonzero;
    logic [NREGS-1:0]      w_busy_next;
    logic                  w_conflict;

    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [XLEN-1:0]       r_wr_data;
    logic [NREGS-1:0]      r_busy;
    logic                  r_conflict;

    // Nothing is granted during a flush or while reset is held, so no write
    // can slip in during either
    assign w_req_eff = i_req_valid & {NUM_REQ{reset_n & ~i_flush}};

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (w_req_eff),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // The grant is already qualified by valid, so any grant bit is an accept
    assign w_accept    = |w_grant;
    assign o_req_ready = w_grant;

    assign w_sel_addr    = i_req_address[w_grant_idx*REG_ADDR_W +: REG_ADDR_W];
    assign w_sel_data    = i_req_data[w_grant_idx*XLEN +: XLEN];
    assign w_sel_nonzero = |w_sel_addr;
    assign w_rsv_nonzero = |i_reserve_address;

    // Scoreboard next state: clear on issued write, then set on reservation,
    // flush overrides both; x0 is never pending
    always_comb begin
        w_busy_next = r_busy;
        if (w_accept && w_sel_nonzero) begin
            w_busy_next[w_sel_addr] = 1'b0;
        end
        // A reservation is only a conflict if the register is still pending
        // after this cycle's writeback has been retired
        w_conflict = i_reserve_valid && w_rsv_nonzero && w_busy_next[i_reserve_address];
        if (i_reserve_valid && w_rsv_nonzero) begin
            w_busy_next[i_reserve_address] = 1'b1;
        end
        if (i_flush) begin
            w_busy_next = '0;
        end
        w_busy_next[0] = 1'b0;
    end

    // Registered write port: enable only for the cycle after an accept, and
    // never for x0; address/data hold between writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_en   <= w_sel_nonzero;
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Pending-write mask and the one-cycle double-reservation pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_conflict <= w_conflict;
        end
    end

    assign o_write_enable     = r_wr_en;
    assign o_write_address    = r_wr_addr;
    assign o_write_data       = r_wr_data;
    assign o_busy_mask        = r_busy;
    assign o_reserve_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req_v;
    wb_req_t     req [3];
    logic        rsv_v;
    logic [4:0]  rsv_a;
    logic        flush;

    logic [2:0]  o_req_ready;
    logic        o_write_enable;
    logic [4:0]  o_write_address;
    logic [31:0] o_write_data;
    logic [31:0] o_busy_mask;
    logic        o_reserve_conflict;
    logic [14:0] w_addr;
    logic [95:0] w_data;

    assign w_addr = {req[2].address, req[1].address, req[0].address};
    assign w_data = {req[2].data, req[1].data, req[0].data};

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NUM_REQ    (3),
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_req_valid        (req_v),
        .o_req_ready        (o_req_ready),
        .i_req_address      (w_addr),
        .i_req_data         (w_data),
        .i_reserve_valid    (rsv_v),
        .i_reserve_address  (rsv_a),
        .i_flush            (flush),
        .o_write_enable     (o_write_enable),
        .o_write_address    (o_write_address),
        .o_write_data       (o_write_data),
        .o_busy_mask        (o_busy_mask),
        .o_reserve_conflict (o_reserve_conflict)
    );

    // Behavioural model state
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          m_conf;
    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_conf = 1'b0;
    endtask

    function automatic int model_grant();
        if (!reset_n || flush) return -1;
        for (int i = 0; i < 3; i++) begin
            if (req_v[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
        end
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model, check the
    // registered outputs just after the edge. Returns the granted index.
    task automatic step(output int g);
        bit [31:0] nb;
        bit        nc;
        #1;
        g = model_grant();
        check("ready", o_req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        nb = m_busy;
        if (g >= 0 && req[g].address != 0) nb[req[g].address] = 1'b0;
        nc = rsv_v && rsv_a != 0 && nb[rsv_a];
        if (rsv_v && rsv_a != 0) nb[rsv_a] = 1'b1;
        if (flush) nb = '0;
        @(posedge clk);
        m_busy = nb;
        m_conf = nc;
        if (g >= 0) begin
            m_ptr  = (g + 1) % 3;
            m_we   = (req[g].address != 0);
            m_addr = req[g].address;
            m_data = req[g].data;
        end else begin
            m_we = 1'b0;
        end
        #1;
        check("wr_en",    o_write_enable,     m_we);
        check("wr_addr",  o_write_address,    m_addr);
        check("wr_data",  o_write_data,       m_data);
        check("busy",     o_busy_mask,        m_busy);
        check("conflict", o_reserve_conflict, m_conf);
        if (o_write_enable) rf[o_write_address] = o_write_data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    o_write_enable,     0);
        check({tag, "_addr"},  o_write_address,    0);
        check({tag, "_data"},  o_write_data,       0);
        check({tag, "_busy"},  o_busy_mask,        0);
        check({tag, "_conf"},  o_reserve_conflict, 0);
        check({tag, "_ready"}, o_req_ready,        0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_v   = '0;
        rsv_v   = 1'b0;
        flush   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        int g;
        req_v = '0;
        rsv_v = 1'b0;
        rsv_a = '0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) step(g);

        // Single ALU write of x5
        req[REQ_ALU] = '{5'd5, 32'hDEADBEEF};
        req_v = 3'b001;
        step(g);
        check("alu_grant", g, REQ_ALU);
        check("alu_we", o_write_enable, 1);
        req_v = '0;
        step(g);
        check("rf_x5", rf[5], 32'hDEADBEEF);

        // All three valid from a fresh pointer: 0,1,2,0,1,2
        do_reset();
        for (int k = 0; k < 3; k++) req[k] = '{5'(k + 10), $urandom};
        req_v = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step(g);
            check("rr_order", g, i % 3);
            if (g >= 0) req[g] = '{5'($urandom_range(1, 31)), $urandom};
        end
        req_v = '0;

        // Load writes x0: consumed, never written
        req[REQ_LOAD] = '{5'd0, 32'h12345678};
        req_v = 3'b010;
        step(g);
        check("x0_grant", g, REQ_LOAD);
        check("x0_we", o_write_enable, 0);
        req_v = '0;
        step(g);
        check("rf_x0", rf[0], 0);

        // Reserve x7, mul/div writes it three cycles later
        rsv_v = 1'b1; rsv_a = 5'd7;
        step(g);
        rsv_v = 1'b0;
        step(g);
        step(g);
        check("busy7_pre", o_busy_mask[7], 1);
        req[REQ_MULDIV] = '{5'd7, 32'hCAFE0007};
        req_v = 3'b100;
        step(g);
        check("busy7_post", o_busy_mask[7], 0);
        req_v = '0;

        // Same-cycle reserve and write of x9: set wins
        rsv_v = 1'b1; rsv_a = 5'd9;
        req[REQ_ALU] = '{5'd9, 32'h00000009};
        req_v = 3'b001;
        step(g);
        check("busy9", o_busy_mask[9], 1);
        check("busy9_conf", o_reserve_conflict, 0);
        rsv_v = 1'b0;
        step(g);
        req_v = '0;

        // Build mask 0x180 with a write of x3 in flight, then flush
        rsv_v = 1'b1; rsv_a = 5'd7;
        step(g);
        rsv_a = 5'd8;
        req[REQ_ALU] = '{5'd3, 32'h33333333};
        req_v = 3'b001;
        step(g);
        rsv_v = 1'b0;
        check("mask_180", o_busy_mask, 32'h0000_0180);
        req[REQ_ALU] = '{5'd4, 32'h44444444};
        flush = 1'b1;
        #1;
        check("flush_ready", o_req_ready, 0);
        check("flush_prior_we", o_write_enable, 1);
        check("flush_prior_addr", o_write_address, 3);
        step(g);
        check("flush_mask", o_busy_mask, 0);
        check("flush_no_we", o_write_enable, 0);
        flush = 1'b0;
        step(g);
        check("post_flush_addr", o_write_address, 4);
        req_v = '0;

        // Asynchronous reset in the middle of traffic
        for (int k = 0; k < 3; k++) req[k] = '{5'(k + 20), $urandom};
        req_v = 3'b111;
        rsv_v = 1'b1; rsv_a = 5'd12;
        step(g);
        check("pre_rst_we", o_write_enable, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        rsv_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(g);
        check("rst_ptr_grant", g, 0);
        req_v = '0;
        step(g);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req_v[k] && $urandom_range(0, 1) == 1) begin
                    req_v[k] = 1'b1;
                    req[k]   = '{5'($urandom_range(0, 31)), $urandom};
                end
            end
            rsv_v = ($urandom_range(0, 2) == 0);
            rsv_a = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 19) == 0);
            step(g);
            if (g >= 0) req_v[g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources: ALU, load unit and mul/div.
- Uses round-robin arbitration with a valid/ready handshake per source.
- Registers the winning write into the register file write port.
- Keeps a pending-write scoreboard (busy mask) for the issue stage. The mask is set on destination reservation and cleared when the write is issued.

Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = mul/div.
- XLEN, 32, write data width.
- REG_ADDR_W, 5, register address width; 2**REG_ADDR_W registers.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- i_req_valid  input  NUM_REQ  per-requester write request.
- o_req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- i_req_address  input  NUM_REQ*REG_ADDR_W  packed destination addresses; requester k uses slice k.
- i_req_data  input  NUM_REQ*XLEN  packed write data.
- i_reserve_valid  input  1  issue stage claims a destination.
- i_reserve_address  input  REG_ADDR_W  claimed destination.
- i_flush  input  1  pipeline flush.
- o_write_enable  output  1  to register file i_write_enable.
- o_write_address  output  REG_ADDR_W  to register file i_write_address.
- o_write_data  output  XLEN  to register file i_write_data.
- o_busy_mask  output  2**REG_ADDR_W  bit r = write to register r pending.
- o_reserve_conflict  output  1  registered one-cycle error pulse.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, rr_ptr = 0, busy mask = 0. A write accepted in the cycle reset asserts is lost.
- Arbitration is combinational:
  - The grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - o_req_ready is set for the granted requester only; all-zero when there is no valid requester or i_flush = 1.
  - Ready may depend on valid. A requester's valid must not depend on its ready.
- Accept = i_req_valid[k] && o_req_ready[k]. A requester holds valid, address and data stable until accepted.
- On accept of requester g: rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Write port is registered, with latency exactly 1 cycle:
  - Cycle after an accept: o_write_enable = (address != 0); o_write_address and o_write_data equal the accepted values.
  - A write to x0 is accepted and consumed, but o_write_enable stays 0.
  - With no accept, o_write_enable = 0. Address and data hold their last values.
- Throughput: one write per cycle. A requester held valid continuously is granted at least once every NUM_REQ cycles (no starvation).
- Scoreboard update at each clock edge, in order:
  1. Clear: an accept of address a != 0 clears busy[a].
  2. Set: i_reserve_valid with address r != 0 sets busy[r].
  - Same-cycle clear and set of the same address: set wins, result is 1.
  - busy[0] is constant 0.
  - Reserve of an address already busy: busy stays 1 and o_reserve_conflict pulses 1 the next cycle. Upstream must never do this; the pulse is an assertion aid.
- Flush: i_flush = 1 clears the entire busy mask at the clock edge, overriding same-cycle set and clear. There are no accepts in that cycle. A write already in the output register (accepted the cycle before) still completes. rr_ptr is unchanged.
- Reservation and writeback of a register in the same cycle with no prior reserve is legal; the set wins.

Decomposition:
- Package regfile_pkg holds:
  - XLEN, REG_ADDR_W, NUM_REGS.
  - Requester index constants REQ_ALU, REQ_LOAD, REQ_MULDIV.
  - typedef wb_req_t {logic [REG_ADDR_W-1:0] address; logic [XLEN-1:0] data;}.
- Sub-module rr_arbiter, parameter N:
  - Ports: request vector, advance strobe, one-hot grant, grant index.
  - Owns rr_ptr and is reusable for later memory-port sharing.
- Scoreboard and output register stay in regfile_wb_arbiter.

Test Plan:
- Reset then idle: o_write_enable = 0, o_busy_mask = 0, o_req_ready = 000 for 5 cycles.
- Single ALU write x5 = 0xDEADBEEF: ready[0] = 1 the same cycle. Next cycle: o_write_enable = 1, address 5, data 0xDEADBEEF. Register file read of x5 returns 0xDEADBEEF afterwards.
- All 3 valid for 6 cycles, rr_ptr = 0: grant order 0,1,2,0,1,2. Each requester drops valid on accept and re-raises new data.
- Write to x0 from load: accepted (ready[1] = 1), o_write_enable stays 0, register x0 still reads 0.
- Reserve x7, then 3 cycles later mul/div writes x7: busy[7] = 1 through the accept edge, 0 afterwards. Same-cycle reserve x9 and write x9: busy[9] = 1.
- Busy mask 0x0000_0180, i_flush with requester 0 valid: mask becomes 0, no accept that cycle. Prior-cycle write still issues. Assert reset_n low mid-stream: outputs 0 immediately (asynchronous).
